// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Access sizes follow instruction bits [14:12].
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B   = 4'b0001;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables / replication and
// load lane selection with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lane,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    illegal   = 1'b0;
    case (st_funct3)
      F3_B, F3_BU: begin
        be        = BE_B << st_lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be        = st_lane[1] ? BE_HHI : BE_HLO;
        wdata_rep = {2{wdata[15:0]}};
        illegal   = st_lane[0];
      end
      F3_W: begin
        be      = BE_W;
        illegal = |st_lane;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    lb    = rdata[{ld_lane, 3'b000} +: 8];
    lh    = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    ldata = rdata;
    case (ld_funct3)
      F3_B:    ldata = {{24{lb[7]}}, lb};
      F3_BU:   ldata = {24'b0, lb};
      F3_H:    ldata = {{16{lh[15]}}, lh};
      F3_HU:   ldata = {16'b0, lh};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access controller with
// req/ack handshake, byte enables and a bus timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        wb_en,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        err_q;
  logic        rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] ld_c;
  logic        ill_c;
  logic        access;
  logic        illegal;
  logic        timeout;

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_lane   (addr[1:0]),
    .wdata     (wdata),
    .be        (be_c),
    .wdata_rep (wd_c),
    .illegal   (ill_c),
    .ld_funct3 (f3_q),
    .ld_lane   (lane_q),
    .rdata     (mem_rdata),
    .ldata     (ld_c)
  );

  assign access  = mem_read | mem_write;
  assign illegal = ill_c | (mem_read & mem_write);
  assign timeout = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    wb_en    = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        stall = access;
        if (access)
          state_nx = illegal ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_ack || timeout)
          state_nx = S_DONE;
      end
      S_DONE: begin
        wb_en    = rd_q & ~err_q;
        err      = err_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (access) begin
            rd_q   <= mem_read;
            f3_q   <= funct3;
            lane_q <= addr[1:0];
            err_q  <= illegal;
            cnt    <= '0;
            if (illegal) begin
              if (mem_read)
                load_data <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wd_c;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 8'd1;
          // ack wins over a coincident timeout
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (rd_q)
              load_data <= ld_c;
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err_q   <= 1'b1;
            if (rd_q)
              load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a
// scoreboard of expected load/error completions.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] load_data;
  logic        stall;
  logic        wb_en;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  typedef struct packed {
    logic        err;
    logic        wb;
    logic [31:0] ld;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  int          s_n, r_n;
  logic [31:0] q_addr, q_wd;
  logic [3:0]  q_be;
  logic        q_we, stable, req_done;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .load_data (load_data),
    .stall     (stall),
    .wb_en     (wb_en),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (wb_en || err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected wb_en=%b err=%b load_data=%h",
                 wb_en, err, load_data);
      end else begin
        e = sb.pop_front();
        if ({err, wb_en, load_data} !== {e.err, e.wb, e.ld}) begin
          errors++;
          $display("FAIL sb_result got err=%b wb=%b ld=%h exp err=%b wb=%b ld=%h",
                   err, wb_en, load_data, e.err, e.wb, e.ld);
        end
      end
    end
  end

  task automatic do_access(
    input logic rd, input logic wr, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rdat, input int ack_delay,
    output int stall_n, output int req_n,
    output logic [31:0] qa, output logic [3:0] qb,
    output logic [31:0] qw, output logic qwe,
    output logic stab, output logic rq_done);
    int   cyc;
    logic fin;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; wdata = wd; mem_rdata = rdat;
    stall_n = 0; req_n = 0; stab = 1'b1; fin = 1'b0;
    rq_done = 1'b0; cyc = 0;
    qa = '0; qb = '0; qw = '0; qwe = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (stall) stall_n++;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          qa = mem_addr; qb = mem_be; qw = mem_wdata; qwe = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {qa, qb, qw, qwe})
          stab = 1'b0;
        mem_ack = (req_n > ack_delay);
      end else
        mem_ack = 1'b0;
      if (!stall) begin
        fin = 1'b1;
        rq_done = mem_req;
      end else if (cyc > 40) begin
        fin = 1'b1;
        checks++; errors++;
        $display("FAIL access_bound still stalled after %0d cycles", cyc);
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, wb_en, err, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000", {mem_req, mem_we, wb_en, err, stall});
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, load_data} !== 100'b0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h exp 0",
               mem_addr, mem_be, mem_wdata, load_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, stall, err, wb_en} !== 4'b0) begin
      errors++;
      $display("FAIL late_ack got %b exp 0000", {mem_req, stall, err, wb_en});
    end
  endtask

  task automatic test_lw();
    sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    do_access(1, 0, F3_W, 32'h100, 0, 32'hDEADBEEF, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if ({q_addr, q_be, q_we} !== {32'h100, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL lw_bus got %h %b %b exp 00000100 1111 0", q_addr, q_be, q_we);
    end
    checks++;
    if (s_n != 2 || r_n != 1) begin
      errors++;
      $display("FAIL lw_timing got stall=%0d req=%0d exp 2 1", s_n, r_n);
    end
  endtask

  task automatic test_lb_lbu();
    sb.push_back('{1'b0, 1'b1, 32'hFFFFFF80});
    do_access(1, 0, F3_B, 32'h103, 0, 32'h80FFFFFF, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if ({q_addr, q_be} !== {32'h100, 4'b1000}) begin
      errors++;
      $display("FAIL lb_bus got %h %b exp 00000100 1000", q_addr, q_be);
    end
    sb.push_back('{1'b0, 1'b1, 32'h00000080});
    do_access(1, 0, F3_BU, 32'h103, 0, 32'h80FFFFFF, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    sb.push_back('{1'b0, 1'b1, 32'hFFFF8001});
    do_access(1, 0, F3_H, 32'h202, 0, 32'h80017FFF, 1,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if (q_be !== 4'b1100) begin
      errors++;
      $display("FAIL lh_be got %b exp 1100", q_be);
    end
    sb.push_back('{1'b0, 1'b1, 32'h00007FFF});
    do_access(1, 0, F3_HU, 32'h200, 0, 32'h80017FFF, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
  endtask

  task automatic test_sh();
    do_access(0, 1, F3_H, 32'h22, 32'h1234ABCD, 0, 3,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if ({q_addr, q_be, q_wd, q_we} !== {32'h20, 4'b1100, 32'hABCDABCD, 1'b1}) begin
      errors++;
      $display("FAIL sh_bus got %h %b %h %b exp 00000020 1100 abcdabcd 1",
               q_addr, q_be, q_wd, q_we);
    end
    checks++;
    if (s_n != 5 || !stable) begin
      errors++;
      $display("FAIL sh_timing got stall=%0d stable=%b exp 5 1", s_n, stable);
    end
    do_access(0, 1, F3_B, 32'h31, 32'h000000A5, 0, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if ({q_be, q_wd} !== {4'b0010, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_bus got %b %h exp 0010 a5a5a5a5", q_be, q_wd);
    end
  endtask

  task automatic test_illegal();
    sb.push_back('{1'b1, 1'b0, 32'h0});
    do_access(1, 0, F3_W, 32'h101, 0, 32'h12345678, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if (s_n != 1 || r_n != 0) begin
      errors++;
      $display("FAIL misaligned got stall=%0d req=%0d exp 1 0", s_n, r_n);
    end
    sb.push_back('{1'b1, 1'b0, 32'h0});
    do_access(0, 1, 3'b011, 32'h100, 0, 0, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    sb.push_back('{1'b1, 1'b0, 32'h0});
    do_access(1, 1, F3_W, 32'h100, 0, 0, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if (r_n != 0) begin
      errors++;
      $display("FAIL rd_wr_both got req=%0d exp 0", r_n);
    end
  endtask

  task automatic test_timeout();
    sb.push_back('{1'b0, 1'b1, 32'h000055AA});
    do_access(1, 0, F3_W, 32'h40, 0, 32'h000055AA, 0,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    sb.push_back('{1'b1, 1'b0, 32'h0});
    do_access(1, 0, F3_W, 32'h44, 0, 32'h11111111, 255,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if (r_n != 4 || req_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout got req=%0d req_in_done=%b exp 4 0", r_n, req_done);
    end
    sb.push_back('{1'b0, 1'b1, 32'h77665544});
    do_access(1, 0, F3_W, 32'h48, 0, 32'h77665544, 3,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if (r_n != 4) begin
      errors++;
      $display("FAIL ack_at_limit got req=%0d exp 4", r_n);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_write = 1'b1; funct3 = F3_W;
    addr = 32'h80; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_pre got %b exp 1", mem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_req got %b exp 0", mem_req);
    end
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL mid_idle got %b exp 00", {stall, mem_req});
    end
    do_access(0, 1, F3_W, 32'h44, 32'h11223344, 0, 1,
              s_n, r_n, q_addr, q_be, q_wd, q_we, stable, req_done);
    checks++;
    if ({q_addr, q_be, q_wd, q_we} !== {32'h44, 4'b1111, 32'h11223344, 1'b1}
        || s_n != 3) begin
      errors++;
      $display("FAIL sw_after_reset got %h %b %h %b stall=%0d exp 00000044 1111 11223344 1 3",
               q_addr, q_be, q_wd, q_we, s_n);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_illegal();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access controller sitting directly downstream of the core datapath. It consumes the datapath's ALU result (data address), register read port 2 (store data) and the load/store decode, and drives a request/acknowledge data-memory bus. It returns lane-aligned, sign- or zero-extended load data to the result mux and holds the PC and register write while an access is outstanding. It replaces fixed-delay load waiting with a real handshake, byte enables and a bus timeout.

## Interface
- `TIMEOUT`, default 16: maximum cycles in REQ without `mem_ack` before the access is aborted with an error; legal range 2..255.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `mem_read` input 1: current instruction is a load.
- `mem_write` input 1: current instruction is a store.
- `funct3` input 3: instruction bits [14:12], giving access size and signedness.
- `addr` input 32: byte address from the ALU.
- `wdata` input 32: store data from register read port 2.
- `load_data` output 32: extended load result to the result mux.
- `stall` output 1: high means hold the PC and suppress register write.
- `wb_en` output 1: one-cycle pulse permitting register write for a completed load.
- `err` output 1: one-cycle pulse for a misaligned address, illegal `funct3`, read and write both asserted, or timeout.
- `mem_req` output 1: bus request, registered.
- `mem_we` output 1: bus write strobe, registered.
- `mem_addr` output 32: word-aligned bus address `{addr[31:2],2'b00}`, registered.
- `mem_be` output 4: byte enables, registered.
- `mem_wdata` output 32: lane-replicated store data, registered.
- `mem_rdata` input 32: bus read data, valid when `mem_ack` is high.
- `mem_ack` input 1: bus completion, sampled only in REQ.

## Operation
States are IDLE, REQ and DONE. Reset state is IDLE.

- **IDLE:** if `mem_read` or `mem_write` is high:
  - Legal access: latch address, byte enables, write data, direction, `funct3` and `addr[1:0]`; go to REQ.
  - Illegal access: go to DONE with an error flag and issue no bus request. Illegal means `mem_read` and `mem_write` both high, `funct3` in {011, 110, 111}, a halfword with `addr[0]=1`, or a word with `addr[1:0]≠0`.
- **REQ:** `mem_req=1`. The wait counter increments each cycle.
  - `mem_ack=1`: a read captures `mem_rdata`. Go to DONE.
  - Otherwise, if the counter equals `TIMEOUT-1`: go to DONE with the error flag.
  - `mem_ack` in the same cycle as the timeout: ack wins and there is no error.
- **DONE:** `wb_en=1` only for a successful read; `err=1` if the error flag is set. Always returns to IDLE. The same instruction is still presented in this cycle and must not retrigger an access.
- `stall = (IDLE & (mem_read|mem_write)) | REQ`. This is combinational and low in DONE, so the PC advances at the end of DONE.
- Byte enables and write data:
  - Byte access: `mem_be = 4'b0001<<addr[1:0]`, `mem_wdata = {4{wdata[7:0]}}`.
  - Halfword access: `mem_be = addr[1]?1100:0011`, `mem_wdata = {2{wdata[15:0]}}`.
  - Word access: `mem_be = 1111`.
- Load extraction uses the captured `addr[1:0]` to select the lane. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `load_data` is registered, updated only on a read ack, and holds its value otherwise. It is 0 after an errored load.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `wb_en` and `err` are 0.
  - `mem_addr`, `mem_be`, `mem_wdata` and `load_data` are 0.
  - State is IDLE and the counter is 0.
- Minimum access is 3 cycles when `mem_ack` is high in the first REQ cycle: IDLE, REQ, DONE. An illegal access takes 2 cycles: IDLE, DONE.
- The bus holds `mem_req`, `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` stable from REQ entry until the ack or timeout edge. `mem_req` is low in DONE.
- Reset mid-access clears `mem_req` immediately without waiting for a clock. The memory must tolerate an abandoned request. A late `mem_ack` seen in IDLE or DONE is ignored.
- Counter width is 8 bits. It is cleared on REQ entry.

## Structure
- Shared package `lsu_pkg`:
  - State enum.
  - `funct3` constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Byte-enable constants.
- Sub-module `lsu_align`, purely combinational:
  - Store side: `funct3` and `addr[1:0]` produce byte enables, replicated write data and the illegal flag.
  - Load side: `mem_rdata`, `funct3` and lane produce the extended load data.
- The top level holds the FSM, the counter and the registers. Expected size is roughly 200 lines of RTL.

## Test plan
- LW at addr 0x100, `mem_rdata=0xDEADBEEF`, ack in the first REQ cycle:
  - `mem_addr=0x100`, `mem_be=1111`.
  - `stall` is high for 2 cycles.
  - DONE shows `load_data=0xDEADBEEF` and `wb_en=1`.
- LB then LBU at addr 0x103 with `mem_rdata=0x80FFFFFF`: `load_data` is 0xFFFFFF80, then 0x00000080.
- SH at addr 0x22 with `wdata=0x1234ABCD`, ack after 3 wait cycles:
  - `mem_be=1100`, `mem_wdata=0xABCDABCD`, `mem_we=1`.
  - `stall` is high for 5 cycles; `wb_en` stays 0.
- Misaligned LW at addr 0x101: `mem_req` never rises, `err` pulses in the second cycle, `stall` is high for 1 cycle, `load_data=0`.
- `TIMEOUT=4` with no ack: REQ lasts 4 cycles, `err` pulses, `mem_req` drops. A repeat run with ack in the 4th REQ cycle completes with `err=0`.
- Assert `rst` in the second REQ cycle: `mem_req` goes 0 in the same cycle. After release, the unit is in IDLE and a fresh SW completes normally.
